// File: rtl/inet_chksum_seq_pkg.sv
// inet_chksum_pkg: shared state type, checksum width and last-beat byte mask
package inet_chksum_pkg;
  localparam int CSUM_W = 16;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  function automatic logic [31:0] byte_mask(input logic [1:0] in_bytes);
    return in_bytes == 2'd1 ? 32'hFF00_0000 :
           in_bytes == 2'd2 ? 32'hFFFF_0000 :
           in_bytes == 2'd3 ? 32'hFFFF_FF00 : 32'hFFFF_FFFF;
  endfunction
endpackage

// File: rtl/inet_chksum_seq_if.sv
// inet_chksum_seq_if: word stream in, checksum result out, both valid/ready
interface inet_chksum_seq_if #(parameter int CNT_W = 16);
  import inet_chksum_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_data;
  logic in_last;
  logic [1:0] in_bytes;
  logic out_valid;
  logic out_ready;
  logic [CSUM_W-1:0] out_checksum;
  logic [CNT_W-1:0] out_words;
  modport master(output in_valid, in_data, in_last, in_bytes, out_ready,
                 input in_ready, out_valid, out_checksum, out_words);
  modport slave(input in_valid, in_data, in_last, in_bytes, out_ready,
                output in_ready, out_valid, out_checksum, out_words);
endinterface

// File: rtl/inet_csum_add.sv
// inet_csum_add: one's-complement add of a 32-bit word into a 16-bit sum with end-around carry
module inet_csum_add
  import inet_chksum_pkg::*;
(
  input  logic [CSUM_W-1:0] acc,
  input  logic [31:0]       word,
  output logic [CSUM_W-1:0] sum
);
  logic [17:0] raw;
  logic [16:0] once;
  assign raw  = {2'b0, acc} + {2'b0, word[31:16]} + {2'b0, word[15:0]};
  assign once = {1'b0, raw[15:0]} + {15'b0, raw[17:16]};
  assign sum  = once[15:0] + {15'b0, once[16]};
endmodule

// File: rtl/inet_chksum_seq.sv
// inet_chksum_seq: accumulates a packet's Internet checksum beat by beat and holds the result
module inet_chksum_seq
  import inet_chksum_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  inet_chksum_seq_if.slave bus
);
  state_t state, state_next;
  logic [CSUM_W-1:0] acc, sum, checksum;
  logic [CNT_W-1:0] count, count_inc, words;
  logic [31:0] word;
  logic accept;
  assign accept       = bus.in_valid && bus.in_ready;
  assign word         = bus.in_last ? bus.in_data & byte_mask(bus.in_bytes) : bus.in_data;
  assign count_inc    = &count ? count : count + CNT_W'(1);
  assign bus.in_ready = state != DONE;
  assign bus.out_valid    = state == DONE;
  assign bus.out_checksum = checksum;
  assign bus.out_words    = words;
  inet_csum_add u_add (.acc(acc), .word(word), .sum(sum));
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  // next state: a last beat closes the packet, the consumer's take reopens the input
  always_comb begin
    state_next = state;
    if (state == DONE) state_next = bus.out_ready ? IDLE : DONE;
    else if (accept) state_next = bus.in_last ? DONE : ACCUM;
  end
  // running sum and beat count; the final beat latches the result and clears them
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc      <= '0;
      count    <= '0;
      checksum <= '0;
      words    <= '0;
    end else if (accept) begin
      acc   <= bus.in_last ? '0 : sum;
      count <= bus.in_last ? '0 : count_inc;
      if (bus.in_last) begin
        checksum <= ~sum;
        words    <= count_inc;
      end
    end
endmodule

// File: tb/tb_inet_chksum_seq.sv
// tb_inet_chksum_seq: random and directed packets scored against a queue-based checksum model
module tb_inet_chksum_seq;
  localparam int CNT_W = 16;
  typedef struct packed {
    logic [15:0] csum;
    logic [CNT_W-1:0] words;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  bit rnd_ready = 1'b0;
  exp_t sb[$];
  exp_t got;
  logic [31:0] q[$];
  logic [15:0] held_c;
  logic [CNT_W-1:0] held_w;

  inet_chksum_seq_if #(.CNT_W(CNT_W)) bus ();
  inet_chksum_seq #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: sum all 16-bit halves in wide arithmetic, fold once at the end, complement
  function automatic logic [15:0] ref_csum(input logic [31:0] w[$], input int nb);
    longint s = 0;
    logic [31:0] m;
    int keep = (nb == 0) ? 4 : nb;
    for (int i = 0; i < w.size(); i++) begin
      m = w[i];
      if (i == w.size() - 1)
        for (int b = keep; b < 4; b++) m[8*(3-b) +: 8] = 8'h00;
      s += longint'(m[31:16]) + longint'(m[15:0]);
    end
    while (s >> 16 != 0) s = (s & 64'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  function automatic logic [CNT_W-1:0] ref_words(input int n);
    return (longint'(n) >= (longint'(1) << CNT_W) - 1) ? '1 : CNT_W'(n);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last, input logic [1:0] nb);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = last;
    bus.in_bytes = nb;
    while (!bus.in_ready) begin
      tick();
      if (++t > 1000) begin
        $display("FAIL in_ready_timeout: got 0 expected 1 after 1000 cycles");
        $fatal(1);
      end
    end
    tick();
    bus.in_valid = 1'b0;
    if (last) check("latency_out_valid", bus.out_valid, 1);
  endtask

  task automatic send_pkt(input logic [31:0] w[$], input int nb, input logic [15:0] exp_c,
                          input int gap_at, input int gap_len, input int rnd_gap);
    sb.push_back('{exp_c, ref_words(w.size())});
    for (int i = 0; i < w.size(); i++) begin
      int g = (i == gap_at) ? gap_len : (rnd_gap > 0 && i > 0) ? $urandom_range(0, rnd_gap) : 0;
      repeat (g) tick();
      send_beat(w[i], i == w.size() - 1, 2'(nb));
    end
  endtask

  // monitor: every taken result is compared with the oldest expectation
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) check("unexpected_result", 1, 0);
      else begin
        got = sb.pop_front();
        check("checksum", bus.out_checksum, got.csum);
        check("words", bus.out_words, got.words);
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.in_bytes = '0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_checksum", bus.out_checksum, 0);
    check("rst_out_words", bus.out_words, 0);
    #12 rst_n = 1'b1;
    tick();
    check("rst_in_ready", bus.in_ready, 1);

    q = {32'h45000073};
    send_pkt(q, 0, 16'hBA8C, -1, 0, 0);
    q = {32'hFFFF0001};
    send_pkt(q, 0, 16'hFFFE, -1, 0, 0);
    q = {32'hFFFF0000};
    send_pkt(q, 0, 16'h0000, -1, 0, 0);
    q = {32'h45000073, 32'h00004000, 32'h40110000, 32'hC0A80001, 32'hC0A800C7};
    send_pkt(q, 0, 16'hB861, 2, 2, 0);
    q = {32'hABCDEF12};
    send_pkt(q, 1, 16'h54FF, -1, 0, 0);
    send_pkt(q, 3, 16'h6531, -1, 0, 0);

    // backpressure: result held, input blocked while the next beat waits
    q = {32'h11112222};
    send_pkt(q, 0, ref_csum(q, 0), -1, 0, 0);
    bus.out_ready = 1'b0;
    held_c = bus.out_checksum;
    held_w = bus.out_words;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h33334444;
    bus.in_last = 1'b1;
    bus.in_bytes = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_checksum_stable", bus.out_checksum, held_c);
      check("bp_words_stable", bus.out_words, held_w);
    end
    q = {32'h33334444};
    sb.push_back('{ref_csum(q, 0), ref_words(1)});
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_out_valid", bus.out_valid, 0);
    check("bp_release_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_next_accepted", bus.out_valid, 1);
    tick();

    // reset mid-packet discards the partial sum
    send_beat(32'h12345678, 0, 2'd0);
    send_beat(32'h12345678, 0, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_checksum", bus.out_checksum, 0);
    check("midrst_words", bus.out_words, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("midrst_in_ready", bus.in_ready, 1);
    q = {32'h00010002};
    send_pkt(q, 0, 16'hFFFC, -1, 0, 0);

    // random packets with random gaps and random consumer backpressure
    rnd_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int nb = $urandom_range(0, 3);
      q = {};
      repeat ($urandom_range(1, 12)) q.push_back($urandom);
      if (p % 5 == 0) q[0] = 32'hFFFFFFFF;
      send_pkt(q, nb, ref_csum(q, nb), -1, 0, 2);
    end
    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;

    // beat counter saturation on a packet longer than the counter range
    q = {};
    repeat (65537) q.push_back($urandom);
    send_pkt(q, 2, ref_csum(q, 2), -1, 0, 0);

    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/inet_chksum_seq.md
# inet_chksum_seq

Multi-cycle sequencer that computes the 16-bit Internet (one's-complement) checksum over a packet delivered as a stream of 32-bit words. It accepts one word per cycle under a valid/ready handshake, masks the partial final word, folds end-around carries each beat, and presents the complemented result plus a beat count on a held output handshake. It sits between a packet source (header builder or RX parser) and the consumer that inserts or checks the checksum field.

## Interface
- CNT_W, 16, width of the beat counter `out_words`.
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  `in_data` beat present.
- in_ready  output  1  block can accept a beat.
- in_data  input  32  packet word; bits [31:24] are the first byte on the wire.
- in_last  input  1  marks the final beat of the packet.
- in_bytes  input  2  valid bytes in the last beat; 0 means 4, 1–3 literal. Ignored when `in_last`=0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_checksum  output  16  one's-complement of the folded packet sum.
- out_words  output  CNT_W  number of beats accepted for this packet; saturates at all-ones.

## Operation
- States: IDLE (no packet open, acc=0), ACCUM (packet open), DONE (result held).
- Beat accepted when `in_valid && in_ready`. `in_ready`=1 in IDLE and ACCUM; 0 in DONE.
- Accepted beat transitions:
  - IDLE → ACCUM.
  - If `in_last`=1, IDLE or ACCUM → DONE.
- Last-beat masking, applied before summing:
  - in_bytes=1 keeps [31:24].
  - in_bytes=2 keeps [31:16].
  - in_bytes=3 keeps [31:8].
  - in_bytes=0 keeps all 32 bits.
  - Masked bytes are zeroed.
- Per beat: acc_next = fold(acc + data[31:16] + data[15:0]).
  - The 18-bit raw sum is folded twice: s[15:0]+s[17:16], then again. The result is always 16 bits.
  - No state holds more than 16 bits of sum.
- On accepting the last beat:
  - `out_checksum` is registered as ~acc_next.
  - `out_words` is registered as count+1, saturating.
  - acc and count clear to 0.
- DONE → IDLE when `out_valid && out_ready`. The new packet's first beat is accepted no earlier than the following cycle.
- A folded sum of 0xFFFF yields checksum 0x0000. The result is not remapped.
- No zero-length packets: every packet is at least one beat.

## Timing
- Reset values (async, while rst_n=0):
  - state=IDLE, acc=0, count=0.
  - in_ready=1 after reset deasserts.
  - out_valid=0, out_checksum=0x0000, out_words=0.
- Latency: last beat accepted at edge N; `out_valid`=1 from edge N, i.e. visible in cycle N+1.
- One beat per cycle sustained within a packet. Inter-packet gap is at least 1 cycle (the DONE cycle), plus any stall from `out_ready`=0.
- While out_valid=1 and out_ready=0, `out_checksum`/`out_words` are stable, `in_ready`=0, and in_* are ignored.
- in_valid low mid-packet: state, acc and count are held; there is no timeout.
- Reset mid-packet or in DONE discards the partial sum and any pending result. No output is produced for that packet.
- Counter saturates at 2^CNT_W−1. The checksum remains correct for any length.

## Structure
- Package `inet_chksum_pkg`:
  - state enum (IDLE, ACCUM, DONE).
  - function `byte_mask(in_bytes)` returning the 32-bit mask.
  - constant `CSUM_W`=16.
- Sub-module `inet_csum_add`: combinational; inputs acc[15:0] and word[31:0], output folded 16-bit sum. It is reusable by the RX checker.
- Top module holds the FSM, acc, counter and output registers.

## Test plan
- Single beat 0x45000073, last, bytes=0 → out_checksum=0xBA8C, out_words=1, out_valid one cycle after accept.
- Carry fold: single beat 0xFFFF0001 → sum 0x0001 → out_checksum=0xFFFE; single beat 0xFFFF0000 → out_checksum=0x0000.
- IPv4 header as five beats 0x45000073, 0x00004000, 0x40110000, 0xC0A80001, 0xC0A800C7, with in_valid gaps of 2 cycles between beats 2 and 3 → out_checksum=0xB861, out_words=5.
- Partial last beat:
  - 0xABCDEF12 with bytes=1 → 0x54FF.
  - Same word with bytes=3 → sum 0xABCD+0xEF00 folded = 0x9ACE → 0x6531.
- Backpressure: hold out_ready=0 for 3 cycles after a result; in_valid=1 throughout. Expected: outputs stable, in_ready=0, no beat consumed. Then out_ready=1 → IDLE, and the next packet's beat is accepted the cycle after.
- Reset mid-packet:
  - Assert rst_n=0 after 2 beats of 0x12345678: all outputs at reset values immediately.
  - Then single beat 0x00010002 → 0xFFFC, proving acc was cleared.
